// File: rtl/axi_w_channel_slave_pkg.sv
// Shared AXI definitions: burst encodings, response codes and the one-hot
// responder state type used by the write-channel slave.
package axi_defs;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    DATA = 3'b010,
    RESP = 3'b100
  } state_t;

endpackage

// File: rtl/axi_w_channel_slave_if.sv
// AXI write-side bundle (AW, W and B channels) shared by the interconnect
// master and the write-channel responder.
interface axi_w_channel_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic [ID_WIDTH-1:0]   AWID;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic [ID_WIDTH-1:0]   WID;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic [ID_WIDTH-1:0]   BID;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    output WDATA, WSTRB, WLAST, WID, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BRESP, BID, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    input  WDATA, WSTRB, WLAST, WID, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BRESP, BID, BVALID
  );

endinterface

// File: rtl/axi_w_channel_slave_addr_gen.sv
// Next-beat address for an AXI burst; shared with the read-side responder.
// Only INCR advances; FIXED (and the unsupported WRAP/reserved) hold.
module axi_burst_addr_gen
  import axi_defs::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  always_comb begin
    next_addr = addr;
    if (burst == BURST_INCR) begin
      next_addr = addr + (ADDR_WIDTH'(1) << size);
    end
  end

endmodule

// File: rtl/axi_w_channel_slave.sv
// AXI write-channel responder: one burst at a time, each W beat becomes one
// SRAM write, and a single B response echoes the accepted AWID.
module axi_w_channel_slave
  import axi_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_w_channel_slave_if.slave  axi,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [STRB_WIDTH-1:0] ram_wmask,
  input  logic                  ram_wready
);

  state_t                state;
  state_t                next_state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [3:0]            len;
  logic [3:0]            count;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [ID_WIDTH-1:0]   id;
  logic                  err;
  logic                  last_err;
  logic                  bvalid;
  logic [1:0]            bresp;
  logic [ID_WIDTH-1:0]   bid;

  logic                  aw_ready;
  logic                  w_ready;
  logic                  beat;
  logic                  final_beat;
  logic                  err_now;
  logic                  last_mismatch;

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr),
    .size      (size),
    .burst     (burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state    = state;
    aw_ready      = 1'b0;
    w_ready       = 1'b0;
    beat          = 1'b0;
    final_beat    = 1'b0;
    err_now       = err;
    last_mismatch = 1'b0;
    ram_wen       = 1'b0;
    ram_waddr     = addr;
    ram_wdata     = '0;
    ram_wmask     = '0;
    unique case (state)
      IDLE: begin
        aw_ready = 1'b1;
        if (axi.AWVALID) next_state = DATA;
      end
      DATA: begin
        w_ready       = ram_wready;
        beat          = axi.WVALID && ram_wready;
        final_beat    = (count == len);
        err_now       = err | (axi.WID != id);
        last_mismatch = (axi.WLAST != final_beat);
        ram_wen       = beat && !err_now;
        ram_wdata     = axi.WDATA;
        ram_wmask     = axi.WSTRB;
        if (beat && final_beat) next_state = RESP;
      end
      RESP: begin
        if (bvalid && axi.BREADY) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // err gates the SRAM writes; a misplaced WLAST is only a protocol slip
  // and is tracked separately so it taints the response without dropping data.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr     <= '0;
      len      <= '0;
      size     <= '0;
      burst    <= '0;
      id       <= '0;
      count    <= '0;
      err      <= 1'b0;
      last_err <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      bid      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (axi.AWVALID) begin
            addr     <= axi.AWADDR;
            len      <= axi.AWLEN;
            size     <= axi.AWSIZE;
            burst    <= axi.AWBURST;
            id       <= axi.AWID;
            count    <= '0;
            err      <= axi.AWBURST[1];
            last_err <= 1'b0;
          end
        end
        DATA: begin
          if (beat) begin
            addr     <= next_addr;
            count    <= count + 4'd1;
            err      <= err_now;
            last_err <= last_err | last_mismatch;
            if (final_beat) begin
              bvalid <= 1'b1;
              bid    <= id;
              bresp  <= (err_now | last_err | last_mismatch) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        RESP: begin
          if (bvalid && axi.BREADY) bvalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign axi.AWREADY = aw_ready;
  assign axi.WREADY  = w_ready;
  assign axi.BVALID  = bvalid;
  assign axi.BRESP   = bresp;
  assign axi.BID     = bid;

endmodule

// File: tb/tb_axi_w_channel_slave.sv
// Directed bench for axi_w_channel_slave: a burst-level model predicts the
// SRAM writes and B responses, checked every cycle against the DUT.
module tb_axi_w_channel_slave;
  import axi_defs::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 6;
  localparam int SW = DW / 8;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [SW-1:0] ram_wmask;
  logic          ram_wready;

  axi_w_channel_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axif ();

  axi_w_channel_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .axi        (axif.slave),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_wmask  (ram_wmask),
    .ram_wready (ram_wready)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] mask;
  } wr_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_t;

  wr_t           exp_writes[$];
  b_t            exp_b[$];
  logic [AW-1:0] obs_addr[$];

  int            pass_count = 0;
  int            check_count = 0;
  int            fail_count = 0;
  int            cyc = 0;
  int            aw_cyc = 0;
  int            last_wen_cyc = 0;
  int            bvalid_rise_cyc = 0;
  int            wen_count = 0;
  int            b_count = 0;
  logic          prev_bvalid = 1'b0;
  logic [IW-1:0] last_bid = '0;
  logic [1:0]    last_bresp = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dataOf(input logic [IW-1:0] id, input int i);
    return {8'hA5, 2'b00, id, 8'h00, 8'(i)};
  endfunction

  function automatic logic [SW-1:0] maskOf(input int i);
    return 4'hF ^ 4'(i);
  endfunction

  always @(posedge ACLK) cyc++;

  // Every SRAM write and every B handshake is matched against the model queues.
  always @(negedge ACLK) begin
    wr_t w;
    b_t  b;
    if (ARESETn) begin
      if (ram_wen) begin
        wen_count++;
        last_wen_cyc = cyc;
        obs_addr.push_back(ram_waddr);
        if (exp_writes.size() == 0) begin
          checkOutput("unexpected_write", 64'(ram_wen), 64'd0);
        end else begin
          w = exp_writes.pop_front();
          checkOutput("wr_addr", 64'(ram_waddr), 64'(w.addr));
          checkOutput("wr_data", 64'(ram_wdata), 64'(w.data));
          checkOutput("wr_mask", 64'(ram_wmask), 64'(w.mask));
        end
      end
      if (axif.BVALID && !prev_bvalid) bvalid_rise_cyc = cyc;
      prev_bvalid = axif.BVALID;
      if (axif.BVALID && axif.BREADY) begin
        b_count++;
        last_bid   = axif.BID;
        last_bresp = axif.BRESP;
        if (exp_b.size() == 0) begin
          checkOutput("unexpected_b", 64'(axif.BVALID), 64'd0);
        end else begin
          b = exp_b.pop_front();
          checkOutput("b_id", 64'(axif.BID), 64'(b.id));
          checkOutput("b_resp", 64'(axif.BRESP), 64'(b.resp));
        end
      end
    end else begin
      prev_bvalid = 1'b0;
    end
  end

  // Runs one burst: model prediction, AW, W beats, then B (or a reset abort).
  task automatic applyStimulus(input logic [AW-1:0] addr, input int len, input int size,
                               input logic [1:0] burst, input logic [IW-1:0] id,
                               input int wid_bad, input int wlast_early,
                               input logic [31:0] ready_pat, input int bready_delay,
                               input int abort_at);
    int   n_beats = len + 1;
    int   drive = (abort_at >= 0) ? abort_at : n_beats;
    logic bad = burst[1];
    logic err_b = burst[1];
    logic [1:0] exp_resp;
    logic accepted = 1'b0;
    logic hs;
    int   guard;
    int   i;
    int   k;

    for (int j = 0; j < n_beats; j++) begin
      if (j == wid_bad) bad = 1'b1;
      err_b = err_b | bad;
      if (j == wlast_early && j != len) err_b = 1'b1;
      if (!bad && j < drive) begin
        exp_writes.push_back('{addr: (burst == BURST_INCR) ? addr + (AW'(j) << size) : addr,
                               data: dataOf(id, j), mask: maskOf(j)});
      end
    end
    exp_resp = err_b ? RESP_SLVERR : RESP_OKAY;
    if (abort_at < 0) exp_b.push_back('{id: id, resp: exp_resp});

    obs_addr.delete();
    wen_count = 0;

    axif.AWADDR  = addr;
    axif.AWLEN   = 4'(len);
    axif.AWSIZE  = 3'(size);
    axif.AWBURST = burst;
    axif.AWID    = id;
    axif.AWVALID = 1'b1;
    axif.BREADY  = 1'b0;
    ram_wready   = 1'b1;

    guard = 0;
    while (!accepted && guard < 20) begin
      @(negedge ACLK);
      if (axif.AWVALID && axif.AWREADY) begin
        accepted = 1'b1;
        aw_cyc = cyc;
      end
      @(posedge ACLK);
      #1;
      guard++;
    end
    axif.AWVALID = 1'b0;
    if (!accepted) begin
      checkOutput("aw_accept_timeout", 64'(axif.AWREADY), 64'd1);
      return;
    end

    i = 0;
    k = 0;
    while (i < drive && k < 64) begin
      axif.WVALID = 1'b1;
      axif.WDATA  = dataOf(id, i);
      axif.WSTRB  = maskOf(i);
      axif.WID    = (i == wid_bad) ? (id ^ 6'd1) : id;
      axif.WLAST  = (i == len) || (i == wlast_early);
      ram_wready  = ready_pat[k % 32];
      @(negedge ACLK);
      checkOutput("wready_track", 64'(axif.WREADY), 64'(ram_wready));
      hs = axif.WVALID && axif.WREADY;
      @(posedge ACLK);
      #1;
      if (hs) i++;
      k++;
    end
    axif.WVALID = 1'b0;
    axif.WLAST  = 1'b0;
    ram_wready  = 1'b1;
    if (i != drive) checkOutput("beat_timeout", 64'(i), 64'(drive));

    if (abort_at >= 0) begin
      #2 ARESETn = 1'b0;
      #1;
      checkOutput("rst_bvalid", 64'(axif.BVALID), 64'd0);
      checkOutput("rst_awready", 64'(axif.AWREADY), 64'd1);
      checkOutput("rst_wready", 64'(axif.WREADY), 64'd0);
      checkOutput("rst_wen", 64'(ram_wen), 64'd0);
      @(posedge ACLK);
      #1 ARESETn = 1'b1;
      checkOutput("abort_writes_drained", 64'(exp_writes.size()), 64'd0);
      repeat (4) @(posedge ACLK);
      #1;
      return;
    end

    for (int d = 0; d < bready_delay; d++) begin
      @(negedge ACLK);
      checkOutput("b_hold_valid", 64'(axif.BVALID), 64'd1);
      checkOutput("b_hold_awready", 64'(axif.AWREADY), 64'd0);
      checkOutput("b_hold_id", 64'(axif.BID), 64'(id));
      checkOutput("b_hold_resp", 64'(axif.BRESP), 64'(exp_resp));
      @(posedge ACLK);
      #1;
    end

    axif.BREADY = 1'b1;
    hs = 1'b0;
    guard = 0;
    while (!hs && guard < 20) begin
      @(negedge ACLK);
      if (axif.BVALID && axif.BREADY) hs = 1'b1;
      else checkOutput("awready_before_b", 64'(axif.AWREADY), 64'd0);
      @(posedge ACLK);
      #1;
      guard++;
    end
    axif.BREADY = 1'b0;
    if (!hs) begin
      checkOutput("b_timeout", 64'(axif.BVALID), 64'd1);
    end else begin
      checkOutput("b_drop", 64'(axif.BVALID), 64'd0);
      checkOutput("aw_ready_after_b", 64'(axif.AWREADY), 64'd1);
    end
    checkOutput("writes_drained", 64'(exp_writes.size()), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] incr_addrs[4];
    int b_before;

    axif.AWADDR  = '0;
    axif.AWLEN   = '0;
    axif.AWSIZE  = '0;
    axif.AWBURST = '0;
    axif.AWID    = '0;
    axif.AWVALID = 1'b0;
    axif.WDATA   = '0;
    axif.WSTRB   = '0;
    axif.WLAST   = 1'b0;
    axif.WID     = '0;
    axif.WVALID  = 1'b0;
    axif.BREADY  = 1'b0;
    ram_wready   = 1'b1;

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("reset_awready", 64'(axif.AWREADY), 64'd1);
    checkOutput("reset_wready", 64'(axif.WREADY), 64'd0);
    checkOutput("reset_bvalid", 64'(axif.BVALID), 64'd0);
    checkOutput("reset_bresp", 64'(axif.BRESP), 64'd0);
    checkOutput("reset_bid", 64'(axif.BID), 64'd0);
    checkOutput("reset_wen", 64'(ram_wen), 64'd0);
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;

    $display("[TB] single beat, AW and W together");
    applyStimulus(32'h100, 0, 2, BURST_INCR, 6'd5, -1, -1, 32'hFFFF_FFFF, 0, -1);
    checkOutput("t1_wen_count", 64'(wen_count), 64'd1);
    if (obs_addr.size() > 0) checkOutput("t1_addr", 64'(obs_addr[0]), 64'h100);
    checkOutput("t1_lat_wen", 64'(last_wen_cyc - aw_cyc), 64'd1);
    checkOutput("t1_lat_bvalid", 64'(bvalid_rise_cyc - aw_cyc), 64'd2);
    checkOutput("t1_bid", 64'(last_bid), 64'd5);
    checkOutput("t1_bresp", 64'(last_bresp), 64'd0);

    $display("[TB] INCR burst of four");
    applyStimulus(32'h200, 3, 2, BURST_INCR, 6'd9, -1, -1, 32'hFFFF_FFFF, 0, -1);
    incr_addrs = '{32'h200, 32'h204, 32'h208, 32'h20C};
    checkOutput("t2_wen_count", 64'(wen_count), 64'd4);
    for (int j = 0; j < 4 && j < obs_addr.size(); j++) begin
      checkOutput("t2_addr", 64'(obs_addr[j]), 64'(incr_addrs[j]));
    end
    checkOutput("t2_bresp", 64'(last_bresp), 64'd0);

    $display("[TB] FIXED burst with ram_wready toggling");
    applyStimulus(32'h40, 2, 2, BURST_FIXED, 6'd2, -1, -1, 32'hFFFF_FFF5, 0, -1);
    checkOutput("t3_wen_count", 64'(wen_count), 64'd3);
    for (int j = 0; j < obs_addr.size(); j++) begin
      checkOutput("t3_addr", 64'(obs_addr[j]), 64'h40);
    end
    checkOutput("t3_bresp", 64'(last_bresp), 64'd0);

    $display("[TB] WRAP burst is refused");
    applyStimulus(32'h300, 1, 2, BURST_WRAP, 6'd12, -1, -1, 32'hFFFF_FFFF, 0, -1);
    checkOutput("t4_wen_count", 64'(wen_count), 64'd0);
    checkOutput("t4_bid", 64'(last_bid), 64'd12);
    checkOutput("t4_bresp", 64'(last_bresp), 64'd2);

    $display("[TB] WID mismatch on beat 0");
    applyStimulus(32'h400, 1, 2, BURST_INCR, 6'd7, 0, -1, 32'hFFFF_FFFF, 0, -1);
    checkOutput("t5_wen_count", 64'(wen_count), 64'd0);
    checkOutput("t5_bresp", 64'(last_bresp), 64'd2);

    $display("[TB] early WLAST on beat 1");
    applyStimulus(32'h500, 2, 2, BURST_INCR, 6'd20, -1, 1, 32'hFFFF_FFFF, 0, -1);
    checkOutput("t6_wen_count", 64'(wen_count), 64'd3);
    checkOutput("t6_bresp", 64'(last_bresp), 64'd2);

    $display("[TB] BREADY held low for five cycles");
    applyStimulus(32'h600, 0, 2, BURST_INCR, 6'd33, -1, -1, 32'hFFFF_FFFF, 5, -1);
    checkOutput("t7_bid", 64'(last_bid), 64'd33);
    checkOutput("t7_bresp", 64'(last_bresp), 64'd0);

    $display("[TB] reset mid-burst");
    b_before = b_count;
    applyStimulus(32'h700, 3, 2, BURST_INCR, 6'd40, -1, -1, 32'hFFFF_FFFF, 0, 2);
    checkOutput("t8_wen_count", 64'(wen_count), 64'd2);
    checkOutput("t8_no_b", 64'(b_count - b_before), 64'd0);

    $display("[TB] single beat after reset");
    applyStimulus(32'h800, 0, 2, BURST_INCR, 6'd3, -1, -1, 32'hFFFF_FFFF, 0, -1);
    checkOutput("t9_wen_count", 64'(wen_count), 64'd1);
    checkOutput("t9_bid", 64'(last_bid), 64'd3);

    repeat (2) @(posedge ACLK);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/axi_w_channel_slave.md
Name: axi_w_channel_slave

Overview:
AXI (AWID/WID style, 4-bit AWLEN) write-channel responder that sits between the AXI interconnect and an SRAM-style write port.
- Accepts one write address, drains its data beats and turns each beat into one SRAM write.
- Returns a single B response carrying the accepted AWID.
- No outstanding transactions: a new AW is accepted only after the previous B handshake completes.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address width
ID_WIDTH, 6, AWID/WID/BID width
STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset; asynchronous assert, active-low
AWADDR  in  ADDR_WIDTH  burst start address
AWLEN  in  4  beats-1
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 fixed, 01 incr, 10 wrap
AWID  in  ID_WIDTH  transaction id
AWVALID  in  1  address valid
AWREADY  out  1  address accepted
WDATA  in  DATA_WIDTH  beat data
WSTRB  in  STRB_WIDTH  byte enables
WLAST  in  1  last beat flag
WID  in  ID_WIDTH  data id
WVALID  in  1  data valid
WREADY  out  1  data accepted
BRESP  out  2  00 OKAY, 10 SLVERR
BID  out  ID_WIDTH  echoed AWID
BVALID  out  1  response valid
BREADY  in  1  response accepted
ram_wen  out  1  SRAM write strobe, one cycle per beat
ram_waddr  out  ADDR_WIDTH  beat address
ram_wdata  out  DATA_WIDTH  beat data
ram_wmask  out  STRB_WIDTH  beat byte mask
ram_wready  in  1  SRAM can take a write this cycle

Behaviour:
- Reset (async, ARESETn=0):
  - state=IDLE, BVALID=0, BRESP=00, BID=0.
  - Internal addr, count, id and err registers are 0.
  - AWREADY=1 and WREADY=0 follow from IDLE.
  - A reset mid-burst abandons the burst; no B is issued.
- One-hot FSM with three states.
- IDLE:
  - AWREADY=1, WREADY=0, BVALID=0.
  - On AWVALID: latch AWADDR, AWLEN, AWSIZE, AWBURST and AWID; clear beat count and err; go to DATA.
  - If AWBURST==10 or 11, set err=1 (wrap/reserved unsupported).
- DATA:
  - AWREADY=0; WREADY = ram_wready (combinational).
  - A beat completes when WVALID&&WREADY.
  - ram_wen = WVALID && WREADY && !err_now, where err_now = err | (WID!=latched id). ram_waddr=current addr, ram_wdata=WDATA, ram_wmask=WSTRB, all combinational.
  - WID mismatch sets err. The beat is still consumed but not written; later beats of the same burst are also not written.
  - Address step per beat:
    - incr: addr += (1<<size), modulo 2^ADDR_WIDTH.
    - fixed: addr unchanged.
  - Count increments per beat. The beat with count==len is final, regardless of WLAST.
  - WLAST must equal (count==len). A mismatch on any beat sets err, but termination still follows count.
  - Final beat: go to RESP; register BVALID=1, BID=id, BRESP = err_final ? 10 : 00, where err_final includes that beat's checks.
- RESP:
  - AWREADY=0, WREADY=0; BVALID and BRESP held stable until BREADY.
  - BVALID&&BREADY: BVALID=0 next cycle, return to IDLE.
  - AWREADY is not asserted in the same cycle as the B handshake; the earliest next AW is accepted the cycle after.
- Latency:
  - Single-beat write with AW and W presented together and ram_wready=1: AW accepted in cycle 0, W in cycle 1, BVALID visible in cycle 2.
- ram_wready low stalls the channel: WREADY is low and no state change occurs.
- WVALID in IDLE or RESP is not accepted (WREADY=0).
- Outputs when not in DATA: ram_wen=0; ram_waddr, ram_wdata and ram_wmask are don't-care, driven as the latched addr and 0.

Decomposition:
- Shared package axi_defs: BURST_FIXED/INCR/WRAP, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the one-hot state constants IDLE/DATA/RESP.
- Optional sub-module axi_burst_addr_gen: next address from addr, size and burst. Kept separate so the read-side responder can reuse it.

Test Plan:
- AW+W same cycle, AWADDR=0x100, AWID=5, AWLEN=0, WLAST=1, WSTRB=0xF, ram_wready=1, BREADY=1 -> one ram_wen at 0x100 in cycle 1; BVALID in cycle 2 with BID=5, BRESP=00.
- INCR burst, AWLEN=3, AWSIZE=2, AWADDR=0x200 -> ram_waddr 0x200, 0x204, 0x208, 0x20C; exactly four ram_wen; one B with OKAY.
- FIXED burst, AWLEN=2, AWADDR=0x40 with ram_wready toggling 1,0,1,0,1 -> WREADY tracks ram_wready; three writes all at 0x40; BRESP=00.
- AWBURST=10, AWLEN=1 -> two beats accepted, no ram_wen, BRESP=10, BID echoes AWID. A second burst with WID!=AWID on beat 0 also yields no writes and BRESP=10.
- WLAST asserted on beat 1 of AWLEN=2 -> all three beats written; burst ends after beat 2; BRESP=10.
- BREADY held 0 for 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout. ARESETn pulsed low mid-burst -> BVALID=0 and AWREADY=1 immediately, no B issued.
